// File: rtl/depth_event_packer_if.sv
// Event-in / stream-out bundle for depth_event_packer.
interface depth_event_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_ts_ns;
  logic [63:0] in_update_id;
  logic        in_side_ask;
  logic [31:0] in_price_f32;
  logic [31:0] in_qty_f32;
  logic [7:0]  in_flags;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;

  modport slave (
    input  in_valid, in_ts_ns, in_update_id, in_side_ask, in_price_f32, in_qty_f32, in_flags,
    output in_ready,
    output m_tvalid, m_tdata, m_tlast,
    input  m_tready
  );

  modport master (
    output in_valid, in_ts_ns, in_update_id, in_side_ask, in_price_f32, in_qty_f32, in_flags,
    input  in_ready,
    input  m_tvalid, m_tdata, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/depth_event_packer.sv
// Packs one depth event into a fixed 7x32-bit stream record with a running 16-bit sequence number.
module depth_event_packer (
  input  logic                        clk,
  input  logic                        rst_n,
  depth_event_packer_if.slave         bus,
  output logic [31:0]                 rec_count
);
  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [63:0] r_ts;
  logic [63:0] r_uid;
  logic        r_side;
  logic [31:0] r_price;
  logic [31:0] r_qty;
  logic [7:0]  r_flags;
  logic [15:0] r_seq;
  logic [31:0] r_rec_count;
  logic        r_tvalid;
  logic [31:0] r_tdata;
  logic        r_tlast;
  logic [31:0] w_next_word;

  // Word that follows the one currently presented; only used on a handshake below index 6.
  always_comb begin
    w_next_word = '0;
    case (r_idx + 3'd1)
      3'd1:    w_next_word = r_ts[63:32];
      3'd2:    w_next_word = r_uid[31:0];
      3'd3:    w_next_word = r_uid[63:32];
      3'd4:    w_next_word = r_price;
      3'd5:    w_next_word = r_qty;
      3'd6:    w_next_word = {r_seq, r_flags, 7'd0, r_side};
      default: w_next_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_ts        <= '0;
      r_uid       <= '0;
      r_side      <= 1'b0;
      r_price     <= '0;
      r_qty       <= '0;
      r_flags     <= '0;
      r_seq       <= '0;
      r_rec_count <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_ts     <= bus.in_ts_ns;
            r_uid    <= bus.in_update_id;
            r_side   <= bus.in_side_ask;
            r_price  <= bus.in_price_f32;
            r_qty    <= bus.in_qty_f32;
            r_flags  <= bus.in_flags;
            r_idx    <= '0;
            r_tvalid <= 1'b1;
            r_tdata  <= bus.in_ts_ns[31:0];
            r_tlast  <= 1'b0;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.m_tready) begin
            if (r_idx == 3'd6) begin
              r_state     <= S_IDLE;
              r_idx       <= '0;
              r_tvalid    <= 1'b0;
              r_tdata     <= '0;
              r_tlast     <= 1'b0;
              r_seq       <= r_seq + 16'd1;
              r_rec_count <= r_rec_count + 32'd1;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_tdata <= w_next_word;
              r_tlast <= (r_idx == 3'd5);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.m_tvalid = r_tvalid;
  assign bus.m_tdata  = r_tdata;
  assign bus.m_tlast  = r_tlast;
  assign rec_count    = r_rec_count;
endmodule

// File: tb/tb_depth_event_packer.sv
// Randomized and directed bench for depth_event_packer against a queue-based record model.
module tb_depth_event_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rec_count;

  depth_event_packer_if bus();

  depth_event_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rec_count (rec_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          acc_t[$];
  logic [15:0] m_seq = 0;
  logic [31:0] m_rec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: an accepted event becomes seven queued words; the record is done when the queue drains.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_seq = 0;
      m_rec = 0;
    end else begin
      cyc++;
      if (exp_q.size() != 0) begin
        if (bus.m_tready) begin
          obs_q.push_back(bus.m_tdata);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_seq = m_seq + 16'd1;
            m_rec = m_rec + 32'd1;
          end
        end
      end else if (bus.in_valid) begin
        exp_q.push_back(bus.in_ts_ns[31:0]);
        exp_q.push_back(bus.in_ts_ns[63:32]);
        exp_q.push_back(bus.in_update_id[31:0]);
        exp_q.push_back(bus.in_update_id[63:32]);
        exp_q.push_back(bus.in_price_f32);
        exp_q.push_back(bus.in_qty_f32);
        exp_q.push_back({m_seq, bus.in_flags, 8'(bus.in_side_ask)});
        acc_cnt++;
        acc_t.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready), 32'(exp_q.size() == 0));
    chk("m_tvalid",  32'(bus.m_tvalid), 32'(exp_q.size() != 0));
    chk("m_tdata",   bus.m_tdata, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
    chk("m_tlast",   32'(bus.m_tlast), 32'(exp_q.size() == 1));
    chk("rec_count", rec_count, m_rec);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ev(input logic [63:0] ts, input logic [63:0] uid, input logic side,
                        input logic [31:0] pr, input logic [31:0] qt, input logic [7:0] fl);
    bus.in_ts_ns = ts; bus.in_update_id = uid; bus.in_side_ask = side;
    bus.in_price_f32 = pr; bus.in_qty_f32 = qt; bus.in_flags = fl;
  endtask

  task automatic wait_acc(input int n0);
    int k;
    for (k = 0; k < 100 && acc_cnt == n0; k++) step();
    if (acc_cnt == n0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_qsize(input int n);
    int k;
    for (k = 0; k < 100 && exp_q.size() != n; k++) step();
    if (exp_q.size() != n) chk("qsize_timeout", 32'(exp_q.size()), 32'(n));
  endtask

  task automatic send_one();
    int n0;
    n0 = acc_cnt;
    bus.in_valid = 1'b1;
    wait_acc(n0);
    bus.in_valid = 1'b0;
    wait_qsize(0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int base;
    int n0;
    logic [31:0] w;
    bus.in_valid = 1'b0;
    bus.m_tready = 1'b1;
    set_ev('0, '0, 1'b0, '0, '0, '0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single bid record with known words
    base = obs_q.size();
    set_ev(64'h0000_0011_2233_4455, 64'h0102030405060708, 1'b0, 32'h42C80000, 32'h3F800000, 8'h00);
    send_one();
    chk("r1_w0", obs_q[base+0], 32'h22334455);
    chk("r1_w1", obs_q[base+1], 32'h00000011);
    chk("r1_w2", obs_q[base+2], 32'h05060708);
    chk("r1_w3", obs_q[base+3], 32'h01020304);
    chk("r1_w4", obs_q[base+4], 32'h42C80000);
    chk("r1_w5", obs_q[base+5], 32'h3F800000);
    chk("r1_w6", obs_q[base+6], 32'h00000000);
    chk("r1_count", rec_count, 32'd1);

    // Second record, ask with flags
    base = obs_q.size();
    set_ev(64'hDEAD_BEEF_0000_0001, 64'h55, 1'b1, 32'h1, 32'h2, 8'hA5);
    send_one();
    chk("r2_w6", obs_q[base+6], 32'h0001A501);

    // Backpressure during w3 with in_valid held high
    base = obs_q.size();
    set_ev(64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 32'h5, 32'h6, 8'h0F);
    n0 = acc_cnt;
    bus.in_valid = 1'b1;
    wait_acc(n0);
    wait_qsize(4);
    bus.m_tready = 1'b0;
    step(); step(); step();
    bus.m_tready = 1'b1;
    n0 = acc_cnt;
    wait_acc(n0);
    bus.in_valid = 1'b0;
    wait_qsize(0);
    chk("bp_gap", 32'(acc_t[acc_t.size()-1] - acc_t[acc_t.size()-2]), 32'd11);
    chk("bp_nwords", 32'(obs_q.size() - base), 32'd14);
    chk("bp_w3", obs_q[base+3], 32'hAAAABBBB);
    chk("bp_w4", obs_q[base+4], 32'h00000005);
    chk("bp_w6", obs_q[base+6], 32'h00020F00);

    // Continuous accepts from a fresh reset
    pulse_reset();
    base = obs_q.size();
    n0 = acc_cnt;
    set_ev(64'h77, 64'h88, 1'b1, 32'h9, 32'hA, 8'h3C);
    bus.in_valid = 1'b1;
    wait_acc(n0);
    wait_acc(n0 + 1);
    wait_acc(n0 + 2);
    bus.in_valid = 1'b0;
    wait_qsize(0);
    chk("cont_gap1", 32'(acc_t[acc_t.size()-2] - acc_t[acc_t.size()-3]), 32'd8);
    chk("cont_gap2", 32'(acc_t[acc_t.size()-1] - acc_t[acc_t.size()-2]), 32'd8);
    chk("cont_count", rec_count, 32'd3);
    w = obs_q[base+6];  chk("cont_seq0", 32'(w[31:16]), 32'd0);
    w = obs_q[base+13]; chk("cont_seq1", 32'(w[31:16]), 32'd1);
    w = obs_q[base+20]; chk("cont_seq2", 32'(w[31:16]), 32'd2);

    // Randomized traffic and backpressure
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.m_tready = ($urandom_range(0, 3) != 0);
      set_ev({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
             $urandom, $urandom, 8'($urandom));
      step();
    end
    bus.in_valid = 1'b0;
    bus.m_tready = 1'b1;
    wait_qsize(0);

    // Reset asserted while w4 is presented
    set_ev(64'h1, 64'h2, 1'b1, 32'h3, 32'h4, 8'h5);
    n0 = acc_cnt;
    bus.in_valid = 1'b1;
    wait_acc(n0);
    bus.in_valid = 1'b0;
    wait_qsize(3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("arst_tlast", 32'(bus.m_tlast), 32'd0);
    chk("arst_tdata", bus.m_tdata, 32'd0);
    chk("arst_count", rec_count, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    base = obs_q.size();
    set_ev(64'h10, 64'h20, 1'b0, 32'h30, 32'h40, 8'h50);
    send_one();
    chk("post_rst_w6", obs_q[base+6], 32'h00005000);
    chk("post_rst_count", rec_count, 32'd1);

    // Sequence and record-count wrap from preloaded values
    force dut.r_seq = 16'hFFFF;
    force dut.r_rec_count = 32'hFFFF_FFFF;
    m_seq = 16'hFFFF;
    m_rec = 32'hFFFF_FFFF;
    step();
    release dut.r_seq;
    release dut.r_rec_count;
    step();
    base = obs_q.size();
    set_ev(64'h99, 64'h98, 1'b1, 32'h97, 32'h96, 8'h11);
    send_one();
    chk("wrap_w6_a", obs_q[base+6], 32'hFFFF1101);
    chk("wrap_count_a", rec_count, 32'd0);
    set_ev(64'h95, 64'h94, 1'b0, 32'h93, 32'h92, 8'h22);
    send_one();
    chk("wrap_w6_b", obs_q[base+13], 32'h00002200);
    chk("wrap_count_b", rec_count, 32'd1);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/depth_event_packer.md
DEPTH_EVENT_PACKER -- requirements
Module: depth_event_packer

Interface
REQ-001 SHALL have no parameters; record length is fixed at 7 words x 32 bits.
REQ-002 SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: depth event offered.
REQ-005 SHALL have port in_ready, output, 1: event accepted on in_valid & in_ready.
REQ-006 SHALL have port in_ts_ns, input, 64: receive timestamp, ns.
REQ-007 SHALL have port in_update_id, input, 64: exchange update id.
REQ-008 SHALL have port in_side_ask, input, 1: 0 = bid, 1 = ask.
REQ-009 SHALL have port in_price_f32, input, 32: price bits, passed opaque.
REQ-010 SHALL have port in_qty_f32, input, 32: qty bits, passed opaque.
REQ-011 SHALL have port in_flags, input, 8: event flags, passed opaque.
REQ-012 SHALL have port m_tvalid, output, 1: stream word valid.
REQ-013 SHALL have port m_tready, input, 1: downstream ready.
REQ-014 SHALL have port m_tdata, output, 32: stream word.
REQ-015 SHALL have port m_tlast, output, 1: last word of record.
REQ-016 SHALL have port rec_count, output, 32: completed records, wraps.

Function
REQ-017 SHALL implement FSM IDLE -> SEND(word index 0..6) -> IDLE.
REQ-018 SHALL drive in_ready = 1 only in IDLE, combinationally from state.
REQ-019 On accept in IDLE, SHALL latch all in_* fields into a holding register, set index 0 and enter SEND.
REQ-020 SHALL ignore in_* while in SEND.
REQ-021 In SEND, SHALL drive m_tvalid = 1 and m_tdata = word[index].
REQ-022 Word map: w0 = ts[31:0]; w1 = ts[63:32]; w2 = uid[31:0]; w3 = uid[63:32]; w4 = price; w5 = qty; w6 = {seq[15:0], flags[7:0], side_byte[7:0]}.
REQ-023 side_byte SHALL be 8'h00 for bid and 8'h01 for ask, matching the unpack raw side convention.
REQ-024 SHALL assert m_tlast only when index = 6.
REQ-025 SHALL advance index only on m_tvalid & m_tready; m_tdata and m_tlast SHALL hold stable while m_tvalid & !m_tready.
REQ-026 On the w6 handshake, SHALL return to IDLE, increment seq (16-bit, 0xFFFF -> 0x0000) and increment rec_count (0xFFFFFFFF -> 0).
REQ-027 Latency: event accepted at edge N gives w0 valid from edge N+1. With m_tready held 1, the record occupies cycles N+1..N+7 and in_ready returns in cycle N+8.
REQ-028 Minimum period is 8 cycles per record: 7 words plus 1 IDLE cycle. Back-to-back accept without the IDLE cycle is not allowed.
REQ-029 seq in w6 SHALL be the value before the increment; the first record after reset carries seq 0.
REQ-030 m_tvalid SHALL be 0 and m_tlast SHALL be 0 in IDLE; m_tdata SHALL be 0 in IDLE.

Reset
REQ-031 Asserting rst_n low SHALL immediately force IDLE, index 0, holding register 0, seq 0, rec_count 0, m_tvalid 0, m_tlast 0, m_tdata 0.
REQ-032 Reset in mid-record SHALL abandon the partial record without emitting m_tlast; rec_count and seq SHALL not count it.
REQ-033 After reset release, in_ready SHALL be 1 in the first cycle.

Verification
REQ-034 Single bid event: ts=0x0000_0011_2233_4455, uid=0x0102030405060708, price=0x42C80000, qty=0x3F800000, flags=0x00, m_tready=1 -> words 0x22334455, 0x00000011, 0x05060708, 0x01020304, 0x42C80000, 0x3F800000, 0x00000000, with tlast on the 7th word; rec_count = 1.
REQ-035 Ask event with flags=0xA5 as the second record -> w6 = 0x0001A501.
REQ-036 Backpressure: m_tready low for 3 cycles during w3 -> w3 held unchanged, no word lost or duplicated, in_valid held high is not accepted until IDLE.
REQ-037 Continuous in_valid with m_tready=1 -> accepts spaced exactly 8 cycles apart; 3 records give rec_count = 3 and seq 0, 1, 2.
REQ-038 Assert rst_n low during w4 -> m_tvalid = 0 asynchronously; after release the next record carries seq 0 and rec_count counts from 0.
REQ-039 Preload seq to 0xFFFF by driving 65535 records -> the next w6 carries seq 0xFFFF, and the record after it carries seq 0x0000.
